// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the slave-side address-channel arbiters.
//   mst_id_w()        : width of a master index (at least 1 bit)
//   trans_slv_id_w()  : slave-side AXI ID width = master ID width + index width
//   slice_lo()        : LSB position of element idx in a packed vector
//   axi_len_t         : AxLEN type for the default length width
// ---------------------------------------------------------------------------
package sa_pkg;

    localparam int AXI_LEN_W = 3;

    typedef logic [AXI_LEN_W-1:0] axi_len_t;

    // A single master still needs a 1-bit index so the ID concatenation is legal.
    function automatic int mst_id_w(input int mst_amt);
        return (mst_amt > 1) ? $clog2(mst_amt) : 1;
    endfunction

    function automatic int trans_slv_id_w(input int trans_mst_id_w, input int mst_amt);
        return trans_mst_id_w + mst_id_w(mst_amt);
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sa_aw_channel_arbiter_if.sv
// ---------------------------------------------------------------------------
// sa_aw_channel_arbiter_if
// Bundles the dispatcher-side AW requests, the slave-side AW channel and the
// WDATA order-FIFO push port of one slave port.
//   modport master : the arbiter (consumes dsp_* requests, drives s_AW* / W_*)
//   modport slave  : the surrounding fabric (dispatchers, slave, order FIFO)
// ---------------------------------------------------------------------------
interface sa_aw_channel_arbiter_if
    import sa_pkg::*;
#(
    parameter int MST_AMT          = 3,
    parameter int TRANS_MST_ID_W   = 5,
    parameter int ADDR_WIDTH       = 32,
    parameter int TRANS_DATA_LEN_W = 3
);
    localparam int MST_ID_W       = mst_id_w(MST_AMT);
    localparam int TRANS_SLV_ID_W = trans_slv_id_w(TRANS_MST_ID_W, MST_AMT);

    // dispatcher side (packed, master 0 in the LSBs)
    logic [TRANS_MST_ID_W*MST_AMT-1:0]   dsp_AWID_i;
    logic [ADDR_WIDTH*MST_AMT-1:0]       dsp_AWADDR_i;
    logic [TRANS_DATA_LEN_W*MST_AMT-1:0] dsp_AWLEN_i;
    logic [MST_AMT-1:0]                  dsp_AWVALID_i;
    logic [MST_AMT-1:0]                  dsp_slv_sel_i;
    logic [MST_AMT-1:0]                  dsp_AWREADY_o;

    // slave side
    logic [TRANS_SLV_ID_W-1:0]           s_AWID_o;
    logic [ADDR_WIDTH-1:0]               s_AWADDR_o;
    logic [TRANS_DATA_LEN_W-1:0]         s_AWLEN_o;
    logic                                s_AWVALID_o;
    logic                                s_AWREADY_i;

    // WDATA order FIFO push
    logic                                W_stall_i;
    logic [MST_ID_W-1:0]                 W_mst_id_o;
    logic [TRANS_DATA_LEN_W-1:0]         W_AxLEN_o;
    logic                                W_fifo_order_wr_en_o;

    modport master (
        input  dsp_AWID_i, dsp_AWADDR_i, dsp_AWLEN_i, dsp_AWVALID_i, dsp_slv_sel_i,
        input  s_AWREADY_i, W_stall_i,
        output dsp_AWREADY_o,
        output s_AWID_o, s_AWADDR_o, s_AWLEN_o, s_AWVALID_o,
        output W_mst_id_o, W_AxLEN_o, W_fifo_order_wr_en_o
    );

    modport slave (
        output dsp_AWID_i, dsp_AWADDR_i, dsp_AWLEN_i, dsp_AWVALID_i, dsp_slv_sel_i,
        output s_AWREADY_i, W_stall_i,
        input  dsp_AWREADY_o,
        input  s_AWID_o, s_AWADDR_o, s_AWLEN_o, s_AWVALID_o,
        input  W_mst_id_o, W_AxLEN_o, W_fifo_order_wr_en_o
    );

endinterface

// File: rtl/sa_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sa_rr_arbiter
// Round-robin arbiter with an internal priority pointer. The search starts at
// rr_ptr and walks upward with wrap; after a grant the pointer moves to the
// index just past the winner, so the winner becomes lowest priority.
//   ACLK_i, ARESET_i : clock, asynchronous active-high reset
//   req[N]           : request vector
//   en               : grant enable (no grant and no pointer move when low)
//   gnt[N]           : one-hot grant (all zero when en is low)
//   gnt_idx          : encoded grant index (zero when en is low)
// ---------------------------------------------------------------------------
module sa_rr_arbiter
    import sa_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = mst_id_w(N)
)(
    input  logic             ACLK_i,
    input  logic             ARESET_i,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] rr_ptr_reg;
    logic [IDX_W-1:0] rr_ptr_next;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    int               pos;

    always_comb begin
        found       = 1'b0;
        win_idx     = '0;
        cand_idx    = '0;
        pos         = 0;
        gnt         = '0;
        gnt_idx     = '0;
        rr_ptr_next = rr_ptr_reg;

        // Rotated priority search: candidate k is (rr_ptr + k) mod N.
        for (int k = 0; k < N; k++) begin
            pos = int'(rr_ptr_reg) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand_idx = IDX_W'(pos);
            if (!found && req[cand_idx]) begin
                found   = 1'b1;
                win_idx = cand_idx;
            end
        end

        if (en && found) begin
            gnt[win_idx] = 1'b1;
            gnt_idx      = win_idx;
            rr_ptr_next  = (win_idx == IDX_W'(N-1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/sa_aw_channel_arbiter.sv
// ---------------------------------------------------------------------------
// sa_aw_channel_arbiter
// Slave-side write-address stage: picks one of the dispatcher AW requests
// aimed at this slave (round-robin), registers it into a one-deep output
// slot towards the slave, and in the same grant cycle pushes
// {master index, AxLEN} into the WDATA order FIFO.
//   ACLK_i, ARESET_i : clock, asynchronous active-high reset
//   aw (master)      : dsp_* requests/AWREADY, s_AW* channel, W_* FIFO push
// ---------------------------------------------------------------------------
module sa_aw_channel_arbiter
    import sa_pkg::*;
#(
    parameter int MST_AMT          = 3,
    parameter int OUTSTANDING_AMT  = 8,
    parameter int MST_ID_W         = mst_id_w(MST_AMT),
    parameter int TRANS_MST_ID_W   = 5,
    parameter int TRANS_SLV_ID_W   = TRANS_MST_ID_W + MST_ID_W,
    parameter int ADDR_WIDTH       = 32,
    parameter int TRANS_DATA_LEN_W = 3
)(
    input  logic                    ACLK_i,
    input  logic                    ARESET_i,
    sa_aw_channel_arbiter_if.master aw
);

    // The order FIFO depth lives downstream; only sanity-check it here.
    generate
        if (OUTSTANDING_AMT < 1 || TRANS_SLV_ID_W != TRANS_MST_ID_W + MST_ID_W) begin : g_param_check
            $error("sa_aw_channel_arbiter: inconsistent parameters");
        end
    endgenerate

    logic [TRANS_MST_ID_W-1:0]   mst_awid   [MST_AMT];
    logic [ADDR_WIDTH-1:0]       mst_awaddr [MST_AMT];
    logic [TRANS_DATA_LEN_W-1:0] mst_awlen  [MST_AMT];
    logic [MST_AMT-1:0]          req;

    generate
        for (genvar gi = 0; gi < MST_AMT; gi++) begin : g_unpack
            assign mst_awid[gi]   = aw.dsp_AWID_i[slice_lo(gi, TRANS_MST_ID_W) +: TRANS_MST_ID_W];
            assign mst_awaddr[gi] = aw.dsp_AWADDR_i[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH];
            assign mst_awlen[gi]  = aw.dsp_AWLEN_i[slice_lo(gi, TRANS_DATA_LEN_W) +: TRANS_DATA_LEN_W];
            // A request for another slave must never win here.
            assign req[gi]        = aw.dsp_AWVALID_i[gi] & aw.dsp_slv_sel_i[gi];
        end
    endgenerate

    logic                        s_awvalid_reg;
    logic [TRANS_SLV_ID_W-1:0]   s_awid_reg;
    logic [ADDR_WIDTH-1:0]       s_awaddr_reg;
    logic [TRANS_DATA_LEN_W-1:0] s_awlen_reg;

    logic                        out_free;
    logic                        grant_en;
    logic [MST_AMT-1:0]          gnt;
    logic [MST_ID_W-1:0]         gnt_idx;

    // The slot can take a new entry if it is empty or being drained this
    // cycle. Reset gating keeps AWREADY and the FIFO push low while held.
    assign out_free = ~s_awvalid_reg | aw.s_AWREADY_i;
    assign grant_en = (|req) & out_free & ~aw.W_stall_i & ~ARESET_i;

    sa_rr_arbiter #(
        .N     (MST_AMT),
        .IDX_W (MST_ID_W)
    ) u_rr_arbiter (
        .ACLK_i   (ACLK_i),
        .ARESET_i (ARESET_i),
        .req      (req),
        .en       (grant_en),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    // gnt is one-hot (or zero), so an OR-reduction is a plain mux.
    logic [TRANS_MST_ID_W-1:0]   sel_awid;
    logic [ADDR_WIDTH-1:0]       sel_awaddr;
    logic [TRANS_DATA_LEN_W-1:0] sel_awlen;

    always_comb begin
        sel_awid   = '0;
        sel_awaddr = '0;
        sel_awlen  = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            if (gnt[i]) begin
                sel_awid   = sel_awid   | mst_awid[i];
                sel_awaddr = sel_awaddr | mst_awaddr[i];
                sel_awlen  = sel_awlen  | mst_awlen[i];
            end
        end
    end

    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            s_awvalid_reg <= 1'b0;
            s_awid_reg    <= '0;
            s_awaddr_reg  <= '0;
            s_awlen_reg   <= '0;
        end else if (grant_en) begin
            s_awvalid_reg <= 1'b1;
            s_awid_reg    <= {gnt_idx, sel_awid};
            s_awaddr_reg  <= sel_awaddr;
            s_awlen_reg   <= sel_awlen;
        end else if (aw.s_AWREADY_i && s_awvalid_reg) begin
            // Payload is kept; only the valid flag drops.
            s_awvalid_reg <= 1'b0;
        end
    end

    assign aw.dsp_AWREADY_o        = gnt;
    assign aw.W_fifo_order_wr_en_o = grant_en;
    assign aw.W_mst_id_o           = gnt_idx;
    assign aw.W_AxLEN_o            = sel_awlen;

    assign aw.s_AWVALID_o = s_awvalid_reg;
    assign aw.s_AWID_o    = s_awid_reg;
    assign aw.s_AWADDR_o  = s_awaddr_reg;
    assign aw.s_AWLEN_o   = s_awlen_reg;

endmodule

// File: tb/tb_sa_aw_channel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sa_aw_channel_arbiter
// Self-checking bench: reset-state table vectors, hand-written multi-cycle
// sequences and a randomized run, all compared against a transaction-level
// reference model (priority pointer, one output slot, order-FIFO queue).
// ---------------------------------------------------------------------------
module tb_sa_aw_channel_arbiter;
    import sa_pkg::*;

    localparam int N   = 3;
    localparam int IDW = 5;
    localparam int AW  = 32;
    localparam int LW  = 3;
    localparam int MW  = 2;
    localparam int SW  = IDW + MW;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    sa_aw_channel_arbiter_if #(
        .MST_AMT(N), .TRANS_MST_ID_W(IDW), .ADDR_WIDTH(AW), .TRANS_DATA_LEN_W(LW)
    ) aw_if ();

    sa_aw_channel_arbiter #(
        .MST_AMT(N), .OUTSTANDING_AMT(8), .MST_ID_W(MW), .TRANS_MST_ID_W(IDW),
        .TRANS_SLV_ID_W(SW), .ADDR_WIDTH(AW), .TRANS_DATA_LEN_W(LW)
    ) dut (
        .ACLK_i   (ACLK),
        .ARESET_i (ARESET),
        .aw       (aw_if.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    // stimulus state
    logic [N-1:0]   in_valid, in_sel;
    logic           in_stall, in_sready;
    logic [IDW-1:0] in_id   [N];
    logic [AW-1:0]  in_addr [N];
    logic [LW-1:0]  in_len  [N];

    // reference model
    int             m_ptr;
    bit             m_valid;
    logic [SW-1:0]  m_id;
    logic [AW-1:0]  m_addr;
    logic [LW-1:0]  m_len;
    bit             exp_gen;
    int             exp_win;
    int             push_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            aw_if.dsp_AWID_i[i*IDW +: IDW] = in_id[i];
            aw_if.dsp_AWADDR_i[i*AW +: AW] = in_addr[i];
            aw_if.dsp_AWLEN_i[i*LW +: LW]  = in_len[i];
        end
        aw_if.dsp_AWVALID_i = in_valid;
        aw_if.dsp_slv_sel_i = in_sel;
        aw_if.W_stall_i     = in_stall;
        aw_if.s_AWREADY_i   = in_sready;
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_id    = '0;
        m_addr  = '0;
        m_len   = '0;
        push_q.delete();
    endtask

    // Called just after a falling edge: apply inputs, let them settle, then
    // compare every DUT output with the model.
    task automatic settle();
        logic [N-1:0] req;
        logic [N-1:0] exp_ready;
        drive();
        #1;
        req       = in_valid & in_sel;
        exp_gen   = (req != 0) && (!m_valid || in_sready) && !in_stall;
        exp_win   = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (exp_win < 0 && req[i]) exp_win = i;
        end
        exp_ready = exp_gen ? (N'(1) << exp_win) : '0;

        chk("awready", aw_if.dsp_AWREADY_o, exp_ready);
        chk("fifo_wr_en", aw_if.W_fifo_order_wr_en_o, exp_gen);
        if (exp_gen) begin
            chk("w_mst_id", aw_if.W_mst_id_o, exp_win);
            chk("w_axlen", aw_if.W_AxLEN_o, in_len[exp_win]);
        end
        chk("s_awvalid", aw_if.s_AWVALID_o, m_valid);
        chk("s_awid", aw_if.s_AWID_o, m_id);
        chk("s_awaddr", aw_if.s_AWADDR_o, m_addr);
        chk("s_awlen", aw_if.s_AWLEN_o, m_len);

        // Ordering: each slave handshake matches the oldest observed push.
        if (aw_if.s_AWVALID_o && in_sready) begin
            $display("AW xfer: id=0x%0h addr=0x%08h len=%0d", aw_if.s_AWID_o, aw_if.s_AWADDR_o, aw_if.s_AWLEN_o);
            if (push_q.size() == 0) chk("order_push_pending", 0, 1);
            else chk("order_fifo_id", aw_if.s_AWID_o[SW-1:IDW], push_q.pop_front());
        end
        if (aw_if.W_fifo_order_wr_en_o) push_q.push_back(int'(aw_if.W_mst_id_o));
    endtask

    task automatic tick();
        @(posedge ACLK);
        if (exp_gen) begin
            m_valid = 1;
            m_id    = {MW'(exp_win), in_id[exp_win]};
            m_addr  = in_addr[exp_win];
            m_len   = in_len[exp_win];
            m_ptr   = (exp_win + 1) % N;
        end else if (m_valid && in_sready) begin
            m_valid = 0;
        end
        @(negedge ACLK);
    endtask

    task automatic set_idle();
        in_valid = '0; in_sel = '0; in_stall = 0; in_sready = 1;
    endtask

    task automatic do_reset();
        ARESET = 1;
        model_reset();
        drive();
        @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 0;
    endtask

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  sel;
        logic          stall;
        logic [N-1:0]  ready;
        logic          wr;
        logic [MW-1:0] id;
        logic [LW-1:0] len;
    } vec_t;

    vec_t vecs[8];
    int   rr_seq[6] = '{0, 1, 2, 0, 1, 2};
    logic [AW-1:0] held_addr;

    initial begin
        for (int i = 0; i < N; i++) begin
            in_id[i]   = IDW'(i + 4);
            in_addr[i] = AW'(32'h1000_0000 + i * 32'h100);
        end
        in_len[0] = 3'd1; in_len[1] = 3'd3; in_len[2] = 3'd6;
        set_idle();
        model_reset();
        drive();

        // Reset-state single-cycle vectors (pointer at 0, slot empty)
        vecs[0] = '{3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 2'd0, 3'd1};
        vecs[1] = '{3'b010, 3'b010, 1'b0, 3'b010, 1'b1, 2'd1, 3'd3};
        vecs[2] = '{3'b110, 3'b110, 1'b0, 3'b010, 1'b1, 2'd1, 3'd3};
        vecs[3] = '{3'b100, 3'b000, 1'b0, 3'b000, 1'b0, 2'd0, 3'd0};
        vecs[4] = '{3'b111, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 3'd0};
        vecs[5] = '{3'b100, 3'b100, 1'b0, 3'b100, 1'b1, 2'd2, 3'd6};
        vecs[6] = '{3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 2'd0, 3'd0};
        vecs[7] = '{3'b101, 3'b111, 1'b0, 3'b001, 1'b1, 2'd0, 3'd1};
        for (int v = 0; v < 8; v++) begin
            set_idle();
            do_reset();
            in_valid = vecs[v].valid; in_sel = vecs[v].sel; in_stall = vecs[v].stall;
            settle();
            chk("vec_awready", aw_if.dsp_AWREADY_o, vecs[v].ready);
            chk("vec_wr_en", aw_if.W_fifo_order_wr_en_o, vecs[v].wr);
            if (vecs[v].wr) begin
                chk("vec_mst_id", aw_if.W_mst_id_o, vecs[v].id);
                chk("vec_axlen", aw_if.W_AxLEN_o, vecs[v].len);
            end
            tick();
        end

        // Single request from master 1, checked one cycle later on the slave side
        set_idle();
        do_reset();
        in_id[1] = 5'd5; in_addr[1] = 32'h1000; in_len[1] = 3'd3;
        in_valid = 3'b010; in_sel = 3'b010;
        settle();
        chk("t1_awready", aw_if.dsp_AWREADY_o, 3'b010);
        chk("t1_mst_id", aw_if.W_mst_id_o, 1);
        chk("t1_axlen", aw_if.W_AxLEN_o, 3);
        tick();
        in_valid = '0;
        settle();
        chk("t1_s_valid", aw_if.s_AWVALID_o, 1);
        chk("t1_s_id", aw_if.s_AWID_o, 7'b01_00101);
        chk("t1_s_addr", aw_if.s_AWADDR_o, 32'h1000);
        tick();

        // All masters requesting, slave always ready: 0,1,2,0,1,2
        set_idle();
        do_reset();
        in_valid = 3'b111; in_sel = 3'b111;
        for (int c = 0; c < 6; c++) begin
            settle();
            chk("t2_wr_en", aw_if.W_fifo_order_wr_en_o, 1);
            chk("t2_rr_order", aw_if.W_mst_id_o, rr_seq[c]);
            tick();
        end
        in_valid = '0;
        settle();
        tick();

        // Slave not ready for 4 cycles with an output pending
        set_idle();
        do_reset();
        in_sready = 0; in_valid = 3'b001; in_sel = 3'b111;
        settle();
        tick();
        held_addr = in_addr[0];
        in_valid  = 3'b101;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("t3_no_ready", aw_if.dsp_AWREADY_o, 0);
            chk("t3_no_push", aw_if.W_fifo_order_wr_en_o, 0);
            chk("t3_stable_addr", aw_if.s_AWADDR_o, held_addr);
            tick();
        end
        in_sready = 1;
        settle();
        chk("t3_regrant", aw_if.dsp_AWREADY_o, 3'b100);
        tick();
        in_valid = '0;
        settle();
        chk("t3_next_valid", aw_if.s_AWVALID_o, 1);
        chk("t3_next_mst", aw_if.s_AWID_o[SW-1:IDW], 2);
        tick();

        // Stall with empty slot, then stall + drain in the same cycle
        set_idle();
        do_reset();
        in_stall = 1; in_valid = 3'b001; in_sel = 3'b001;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("t4_stall_ready", aw_if.dsp_AWREADY_o, 0);
            chk("t4_stall_push", aw_if.W_fifo_order_wr_en_o, 0);
            chk("t4_stall_valid", aw_if.s_AWVALID_o, 0);
            tick();
        end
        in_stall = 0;
        settle();
        chk("t4_release", aw_if.dsp_AWREADY_o, 3'b001);
        tick();
        in_stall = 1;
        settle();
        chk("t4_drain_push", aw_if.W_fifo_order_wr_en_o, 0);
        tick();
        settle();
        chk("t4_drained", aw_if.s_AWVALID_o, 0);
        tick();

        // Master 2 valid but not targeting this slave; master 0 alone wins
        set_idle();
        do_reset();
        in_valid = 3'b101; in_sel = 3'b001;
        for (int c = 0; c < 6; c++) begin
            settle();
            chk("t5_only_m0", aw_if.dsp_AWREADY_o, 3'b001);
            tick();
        end

        // Asynchronous reset mid-handshake
        set_idle();
        do_reset();
        in_sready = 0; in_valid = 3'b010; in_sel = 3'b111;
        settle();
        tick();
        in_valid = 3'b111;
        settle();
        chk("t6_pending", aw_if.s_AWVALID_o, 1);
        #1 ARESET = 1;
        #1;
        chk("t6_rst_valid", aw_if.s_AWVALID_o, 0);
        chk("t6_rst_addr", aw_if.s_AWADDR_o, 0);
        chk("t6_rst_ready", aw_if.dsp_AWREADY_o, 0);
        chk("t6_rst_push", aw_if.W_fifo_order_wr_en_o, 0);
        model_reset();
        @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 0;
        in_sready = 1;
        settle();
        chk("t6_first_grant", aw_if.dsp_AWREADY_o, 3'b001);
        tick();

        // Randomized traffic against the model
        set_idle();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid  = N'($urandom);
            in_sel    = N'($urandom) | N'($urandom);
            in_stall  = ($urandom_range(0, 4) == 0);
            in_sready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                in_id[i]   = IDW'($urandom);
                in_addr[i] = $urandom;
                in_len[i]  = LW'($urandom);
            end
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
